// File: rtl/stebus_cycle_ctrl.sv
// STEbus master cycle sequencer: one ADRSTB*/DATSTB* cycle per decoded Z180 access, stretching the CPU via WAIT*.
// Build option: define STEBUS_TRFERR_EN to let TRFERR* terminate the data phase and pulse bus_err.
module stebus_cycle_ctrl #(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_wr,
  input  logic       req_io,
  input  logic       datack_n,
  input  logic       trferr_n,
  output logic [2:0] cm,
  output logic       adrstb_n,
  output logic       datstb_n,
  output logic       busdir,
  output logic       zwait_n,
  output logic       timeout,
  output logic       bus_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cm_q, cm_d;
  logic             adrstb_n_q, adrstb_n_d;
  logic             datstb_n_q, datstb_n_d;
  logic             busdir_q, busdir_d;
  logic             zwait_n_q, zwait_n_d;
  logic             timeout_q, timeout_d;
  logic             bus_err_q, bus_err_d;
  logic             dack_s1_q, dack_s1_d;
  logic             dack_s2_q, dack_s2_d;
  logic             ack, err, end_cycle;

  assign ack = ~dack_s2_q;

`ifdef STEBUS_TRFERR_EN
  logic terr_s1_q, terr_s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      terr_s1_q <= 1'b1;
      terr_s2_q <= 1'b1;
    end else begin
      terr_s1_q <= trferr_n;
      terr_s2_q <= terr_s1_q;
    end
  end
  assign err = ~terr_s2_q;
`else
  logic unused_trferr;
  assign unused_trferr = trferr_n;
  assign err = 1'b0;
`endif

  // Handshake: req stays high for the whole CPU access; the bus cycle completes when the
  // synchronised DATACK* is seen in DATA, and a new cycle needs req and ack both low first.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cm_d       = cm_q;
    adrstb_n_d = adrstb_n_q;
    datstb_n_d = datstb_n_q;
    busdir_d   = busdir_q;
    zwait_n_d  = zwait_n_q;
    timeout_d  = 1'b0;
    bus_err_d  = 1'b0;
    dack_s1_d  = datack_n;
    dack_s2_d  = dack_s1_q;
    end_cycle  = 1'b0;
    case (state_q)
      S_IDLE: begin
        zwait_n_d = ~req;
        if (req && !ack) begin
          state_d    = S_ADDR;
          adrstb_n_d = 1'b0;
          cm_d       = {1'b1, ~req_io, ~req_wr};
          busdir_d   = ~req_wr;
          cnt_d      = '0;
        end
      end
      S_ADDR: begin
        if (!req) begin
          end_cycle = 1'b1;
        end else if (cnt_q == SETUP_LAST) begin
          state_d    = S_DATA;
          datstb_n_d = 1'b0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (!req || ack) begin
          end_cycle = 1'b1;
        end else if (err) begin
          end_cycle = 1'b1;
          bus_err_d = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          end_cycle = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // A still-asserted DATACK* would otherwise satisfy the next cycle instantly.
        if (!req && !ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (end_cycle) begin
      state_d    = S_DONE;
      adrstb_n_d = 1'b1;
      datstb_n_d = 1'b1;
      zwait_n_d  = 1'b1;
      cm_d       = 3'b000;
      busdir_d   = 1'b1;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cm_q       <= 3'b000;
      adrstb_n_q <= 1'b1;
      datstb_n_q <= 1'b1;
      busdir_q   <= 1'b1;
      zwait_n_q  <= 1'b1;
      timeout_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      dack_s1_q  <= 1'b1;
      dack_s2_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cm_q       <= cm_d;
      adrstb_n_q <= adrstb_n_d;
      datstb_n_q <= datstb_n_d;
      busdir_q   <= busdir_d;
      zwait_n_q  <= zwait_n_d;
      timeout_q  <= timeout_d;
      bus_err_q  <= bus_err_d;
      dack_s1_q  <= dack_s1_d;
      dack_s2_q  <= dack_s2_d;
    end
  end

  assign cm        = cm_q;
  assign adrstb_n  = adrstb_n_q;
  assign datstb_n  = datstb_n_q;
  assign busdir    = busdir_q;
  assign zwait_n   = zwait_n_q;
  assign timeout   = timeout_q;
  assign bus_err   = bus_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stebus_cycle_ctrl.sv
// Directed bench for stebus_cycle_ctrl: timeline-based reference model checked every cycle,
// plus hand-computed latency and boundary expectations.
module tb_stebus_cycle_ctrl;

  localparam int SETUP = 2;
  localparam int TMO   = 32;

  logic       clk = 1'b0;
  logic       rst, req, req_wr, req_io, datack_n, trferr_n;
  logic [2:0] cm;
  logic       adrstb_n, datstb_n, busdir, zwait_n, timeout, bus_err;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  stebus_cycle_ctrl #(.SETUP_CYC(SETUP), .TIMEOUT_CYC(TMO), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_io(req_io),
    .datack_n(datack_n), .trferr_n(trferr_n), .cm(cm), .adrstb_n(adrstb_n),
    .datstb_n(datstb_n), .busdir(busdir), .zwait_n(zwait_n), .timeout(timeout),
    .bus_err(bus_err), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // reference model: tracks elapsed clocks since ADRSTB* fell, pushes expected outputs
  // {cm, adrstb_n, datstb_n, busdir, zwait_n, timeout, bus_err}
  logic [8:0] exp_q[$];
  bit         m_busy, m_done, m_wr;
  int         m_age;
  logic [2:0] m_cm;
  bit         d1 = 1'b1, d2 = 1'b1, e1 = 1'b1, e2 = 1'b1;

  always @(posedge clk) begin : model_p
    logic [8:0] v;
    bit ack, err, fin, to, be;
    ack = !d2;
`ifdef STEBUS_TRFERR_EN
    err = !e2;
`else
    err = 1'b0;
`endif
    fin = 1'b0;
    to  = 1'b0;
    be  = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_age  = 0;
      d1 = 1'b1; d2 = 1'b1; e1 = 1'b1; e2 = 1'b1;
      v = {3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    end else begin
      if (m_busy) begin
        if (!req) fin = 1'b1;
        else if (m_age >= SETUP) begin
          if (ack) fin = 1'b1;
          else if (err) begin fin = 1'b1; be = 1'b1; end
          else if (m_age == SETUP + TMO - 1) begin fin = 1'b1; to = 1'b1; end
        end
        m_age++;
        if (fin) begin m_busy = 1'b0; m_done = 1'b1; end
      end else if (m_done) begin
        if (!req && !ack) m_done = 1'b0;
      end else if (req && !ack) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_cm   = {1'b1, ~req_io, ~req_wr};
        m_wr   = req_wr;
      end
      if (m_busy)
        v = {m_cm, 1'b0, (m_age >= SETUP) ? 1'b0 : 1'b1, ~m_wr, 1'b0, 1'b0, 1'b0};
      else if (m_done)
        v = {3'b000, 1'b1, 1'b1, 1'b1, 1'b1, to, be};
      else
        v = {3'b000, 1'b1, 1'b1, 1'b1, ~req, 1'b0, 1'b0};
      d2 = d1; d1 = datack_n;
      e2 = e1; e1 = trferr_n;
    end
    exp_q.push_back(v);
  end

  // scoreboard compare: one check per cycle against the model
  always @(negedge clk) begin : compare_p
    logic [8:0] exp_v, got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {cm, adrstb_n, datstb_n, busdir, zwait_n, timeout, bus_err};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got=%b expected=%b (cm,adr,dat,dir,wait,tmo,err)",
                 $time, got_v, exp_v);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic wait_datstb(input string name);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (datstb_n == 1'b0) break;
    end
    chk(name, datstb_n, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cm"}, cm, 0);
    chk({tag, "_adrstb"}, adrstb_n, 1);
    chk({tag, "_datstb"}, datstb_n, 1);
    chk({tag, "_busdir"}, busdir, 1);
    chk({tag, "_zwait"}, zwait_n, 1);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_buserr"}, bus_err, 0);
  endtask

  task automatic close_cycle();
    req = 1'b0; datack_n = 1'b1; trferr_n = 1'b1;
    tick(4);
  endtask

  initial begin
    rst = 1'b1; req = 1'b1; req_wr = 1'b0; req_io = 1'b0;
    datack_n = 1'b1; trferr_n = 1'b1;

    // 1: reset with req held high
    tick(2);
    chk_reset_vals("t1_rst");
    req = 1'b0; rst = 1'b0;
    tick(2);

    // 2: memory read ended by DATACK*
    req_wr = 1'b0; req_io = 1'b0; req = 1'b1;
    tick(1);
    chk("t2_adrstb_plus1", adrstb_n, 0);
    chk("t2_cm_memrd", cm, 3'b111);
    chk("t2_zwait_low", zwait_n, 0);
    chk("t2_busdir_rd", busdir, 1);
    tick(1);
    chk("t2_datstb_plus2", datstb_n, 1);
    tick(1);
    chk("t2_datstb_plus3", datstb_n, 0);
    tick(4);
    datack_n = 1'b0;
    tick(2);
    chk("t2_zwait_ack_plus2", zwait_n, 0);
    tick(1);
    chk("t2_zwait_ack_plus3", zwait_n, 1);
    chk("t2_done_cm", cm, 0);
    chk("t2_done_adrstb", adrstb_n, 1);
    tick(3);
    chk("t2_done_hold_req", adrstb_n, 1);
    req = 1'b0;
    tick(3);
    chk("t2_done_hold_ack", adrstb_n, 1);
    datack_n = 1'b1;
    tick(4);

    // 3: I/O write ended by timeout
    req_wr = 1'b1; req_io = 1'b1; req = 1'b1;
    tick(1);
    chk("t3_cm_iowr", cm, 3'b100);
    chk("t3_busdir_addr", busdir, 0);
    wait_datstb("t3_datstb");
    chk("t3_busdir_data", busdir, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      cnt++;
      if (timeout) break;
    end
    chk("t3_timeout_clks", cnt, TMO);
    chk("t3_timeout_zwait", zwait_n, 1);
    chk("t3_timeout_busdir", busdir, 1);
    chk("t3_timeout_datstb", datstb_n, 1);
    tick(1);
    chk("t3_timeout_pulse_end", timeout, 0);
    req_wr = 1'b0;
    close_cycle();

    // 4a: TRFERR* and DATACK* together: acknowledge wins
    req_io = 1'b0; req = 1'b1;
    wait_datstb("t4a_datstb");
    datack_n = 1'b0; trferr_n = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      cnt++;
      if (zwait_n) break;
    end
    chk("t4a_ack_clks", cnt, 3);
    chk("t4a_buserr", bus_err, 0);
    chk("t4a_timeout", timeout, 0);
    close_cycle();

    // 4b: TRFERR* alone
    req = 1'b1;
    wait_datstb("t4b_datstb");
    trferr_n = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      cnt++;
      if (bus_err || timeout) break;
    end
`ifdef STEBUS_TRFERR_EN
    chk("t4b_err_clks", cnt, 3);
    chk("t4b_buserr", bus_err, 1);
    chk("t4b_timeout", timeout, 0);
    tick(1);
    chk("t4b_buserr_pulse_end", bus_err, 0);
`else
    chk("t4b_ignored_clks", cnt, TMO);
    chk("t4b_ignored_timeout", timeout, 1);
    chk("t4b_ignored_buserr", bus_err, 0);
`endif
    close_cycle();

    // 5: DATACK* stuck low blocks a new cycle
    datack_n = 1'b0;
    tick(3);
    req_io = 1'b1; req = 1'b1;
    tick(3);
    chk("t5_stuck_adrstb", adrstb_n, 1);
    chk("t5_stuck_zwait", zwait_n, 0);
    datack_n = 1'b1;
    tick(2);
    chk("t5_release_adrstb_plus2", adrstb_n, 1);
    tick(1);
    chk("t5_release_adrstb_plus3", adrstb_n, 0);
    chk("t5_cm_iord", cm, 3'b101);
    wait_datstb("t5_datstb");
    datack_n = 1'b0;
    tick(3);
    chk("t5_ack_zwait", zwait_n, 1);
    close_cycle();

    // 6a: req dropped in DATA
    req_io = 1'b0; req = 1'b1;
    wait_datstb("t6a_datstb");
    tick(2);
    req = 1'b0;
    tick(1);
    chk_reset_vals("t6a_abort");
    tick(1);
    req = 1'b1;
    tick(1);
    chk("t6a_next_adrstb", adrstb_n, 0);
    wait_datstb("t6a_next_datstb");
    datack_n = 1'b0;
    tick(3);
    chk("t6a_next_zwait", zwait_n, 1);
    close_cycle();

    // 6b: reset in DATA
    req = 1'b1;
    wait_datstb("t6b_datstb");
    tick(1);
    rst = 1'b1; req = 1'b0;
    tick(1);
    chk_reset_vals("t6b_rst");
    rst = 1'b0;
    tick(1);
    req = 1'b1;
    tick(1);
    chk("t6b_next_adrstb", adrstb_n, 0);
    chk("t6b_next_cm", cm, 3'b111);
    wait_datstb("t6b_next_datstb");
    datack_n = 1'b0;
    tick(3);
    chk("t6b_next_zwait", zwait_n, 1);
    close_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
